// File: rtl/mpsoc_ahb3_master_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_ahb3_master_port_pkg
// Purpose  : Shared AHB3-Lite encodings and the master-port stage control
//            record. The SRAM slave uses the same package.
// Contents : HTRANS/HSIZE/HBURST/HRESP/HPROT encodings, stage_ctrl_t,
//            misaligned() helper.
// Revision : 1.0 - initial release
// ============================================================================
package mpsoc_ahb3_master_port_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Data access, privileged: value driven while no request has been seen.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Control part of a pipeline stage. Address and write data live next to
  // it in the port itself because their widths follow the port parameters.
  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [3:0] prot;
    logic       lock;
    logic       lerr;   // locally detected error: never issued on the bus
  } stage_ctrl_t;

  // A request is misaligned when the address is not a multiple of the
  // transfer size, or when the transfer is wider than the data bus.
  function automatic logic misaligned(input logic [6:0]  adr_lo,
                                      input logic [2:0]  size,
                                      input int unsigned xbytes);
    logic [7:0] nbytes;
    nbytes = 8'd1 << size;
    return ((adr_lo & nbytes[6:0] - 7'd1) != 7'd0) || (32'(nbytes) > xbytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpsoc_ahb3_master_port_if.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_ahb3_master_port_if
// Purpose  : AHB3-Lite bus signals between one master and one slave.
// Modports : master - drives address/control/write data, samples response
//            slave  - the reverse
// Revision : 1.0 - initial release
// ============================================================================
interface mpsoc_ahb3_master_port_if #(
  parameter int PLEN = 64,
  parameter int XLEN = 32
);
  logic [PLEN-1:0] HADDR;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface
`default_nettype wire

// File: rtl/mpsoc_ahb3_master_port.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_ahb3_master_port
// Purpose  : Turns a core-side request/response handshake into pipelined
//            AHB3-Lite single transfers. Stage A drives the address phase,
//            stage D tracks the data phase; responses return in order.
// Ports    : HCLK, HRESETn          - clock, async active-low reset
//            req_*                  - request in (valid/ready handshake)
//            rsp_*                  - one-cycle in-order response strobe
//            ahb (master modport)   - AHB3-Lite bus
// Revision : 1.0 - initial release
// ============================================================================
module mpsoc_ahb3_master_port
  import mpsoc_ahb3_master_port_pkg::*;
#(
  parameter int PLEN = 64,
  parameter int XLEN = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,

  input  logic                    req_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [PLEN-1:0]         req_adr_i,
  input  logic [2:0]              req_size_i,
  input  logic [3:0]              req_prot_i,
  input  logic                    req_lock_i,
  input  logic [XLEN-1:0]         req_dat_i,

  output logic                    rsp_valid_o,
  output logic [XLEN-1:0]         rsp_dat_o,
  output logic                    rsp_err_o,

  mpsoc_ahb3_master_port_if.master ahb
);

  // Address stage
  logic            a_valid_q, a_valid_d;
  stage_ctrl_t     a_ctrl_q,  a_ctrl_d;
  logic [PLEN-1:0] a_adr_q,   a_adr_d;
  logic [XLEN-1:0] a_wdata_q, a_wdata_d;

  // Data stage
  logic            d_valid_q, d_valid_d;
  logic            d_we_q,    d_we_d;
  logic            d_lerr_q,  d_lerr_d;
  logic [XLEN-1:0] d_wdata_q, d_wdata_d;

  logic a_done;
  logic d_done;
  logic accept;
  logic hresp_err;

  always_comb begin
    hresp_err = (ahb.HRESP == HRESP_ERROR);

    // An ERROR response holds A in place until the slave is back to OKAY,
    // which gives the two-cycle error window and the reissue afterwards.
    a_done      = a_valid_q & ahb.HREADY & ~hresp_err;
    req_ready_o = ~a_valid_q | a_done;
    accept      = req_i & req_ready_o;

    // A local-error entry never reached the bus, so nothing to wait for.
    d_done      = d_valid_q & (ahb.HREADY | d_lerr_q);

    a_valid_d = a_valid_q;
    a_ctrl_d  = a_ctrl_q;
    a_adr_d   = a_adr_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_we_d    = d_we_q;
    d_lerr_d  = d_lerr_q;
    d_wdata_d = d_wdata_q;

    if (accept) begin
      a_valid_d     = 1'b1;
      a_ctrl_d.we   = req_we_i;
      a_ctrl_d.size = req_size_i;
      a_ctrl_d.prot = req_prot_i;
      a_ctrl_d.lock = req_lock_i;
      a_ctrl_d.lerr = misaligned(req_adr_i[6:0], req_size_i, XLEN / 8);
      a_adr_d       = req_adr_i;
      a_wdata_d     = req_dat_i;
    end else if (a_done) begin
      a_valid_d = 1'b0;
    end

    if (a_done) begin
      d_valid_d = 1'b1;
      d_we_d    = a_ctrl_q.we;
      d_lerr_d  = a_ctrl_q.lerr;
      d_wdata_d = a_wdata_q;
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q     <= 1'b0;
      a_ctrl_q.we   <= 1'b0;
      a_ctrl_q.size <= HSIZE_BYTE;
      a_ctrl_q.prot <= HPROT_DEFAULT;
      a_ctrl_q.lock <= 1'b0;
      a_ctrl_q.lerr <= 1'b0;
      a_adr_q       <= '0;
      a_wdata_q     <= '0;
      d_valid_q     <= 1'b0;
      d_we_q        <= 1'b0;
      d_lerr_q      <= 1'b0;
      d_wdata_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_ctrl_q  <= a_ctrl_d;
      a_adr_q   <= a_adr_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_we_q    <= d_we_d;
      d_lerr_q  <= d_lerr_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  // Bus side: control mirrors A and is therefore stable through wait states.
  assign ahb.HTRANS    = (a_valid_q & ~a_ctrl_q.lerr & ~hresp_err) ? HTRANS_NONSEQ
                                                                   : HTRANS_IDLE;
  assign ahb.HADDR     = a_adr_q;
  assign ahb.HWRITE    = a_ctrl_q.we;
  assign ahb.HSIZE     = a_ctrl_q.size;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = a_ctrl_q.prot;
  assign ahb.HMASTLOCK = a_ctrl_q.lock;
  assign ahb.HWDATA    = d_wdata_q;

  // Core side response; read data is zero outside read completions.
  assign rsp_valid_o = d_done;
  assign rsp_err_o   = d_done & (hresp_err | d_lerr_q);
  assign rsp_dat_o   = (d_done & ~d_we_q) ? ahb.HRDATA : '0;

endmodule
`default_nettype wire

// File: doc/mpsoc_ahb3_master_port.md
Name: mpsoc_ahb3_master_port

Overview:
AHB3-Lite master port that turns a simple core-side request/response handshake into pipelined AHB3-Lite single transfers.
Sits directly upstream of the AHB3 single-port SRAM slave, via the interconnect or point-to-point.
Overlaps the address phase of transfer N+1 with the data phase of transfer N, handles wait states and the two-cycle ERROR response, and returns in-order responses.

Parameters:
PLEN, 64, address width
XLEN, 32, data width; legal values 8..1024, power of two

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset
req_i  in  1  request valid
req_ready_o  out  1  request accepted this cycle when req_i & req_ready_o
req_we_i  in  1  1=write, 0=read
req_adr_i  in  PLEN  byte address
req_size_i  in  3  HSIZE encoding
req_prot_i  in  4  HPROT value
req_lock_i  in  1  locked access
req_dat_i  in  XLEN  write data, lane-aligned; sampled at acceptance
rsp_valid_o  out  1  one-cycle response strobe
rsp_dat_o  out  XLEN  read data, valid with rsp_valid_o on reads
rsp_err_o  out  1  error flag, valid with rsp_valid_o
HADDR  out  PLEN  AHB address
HWRITE  out  1  AHB write
HSIZE  out  3  AHB size
HBURST  out  3  always SINGLE
HPROT  out  4  AHB protection
HTRANS  out  2  IDLE or NONSEQ only
HMASTLOCK  out  1  AHB lock
HWDATA  out  XLEN  write data, data phase
HRDATA  in  XLEN  read data
HREADY  in  1  transfer ready
HRESP  in  1  OKAY(0)/ERROR(1)

Behaviour:
- Clock/reset: HRESETn is asynchronous, active-low; HCLK is the clock.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=SINGLE, HPROT=4'b0011, HMASTLOCK=0, HWDATA=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0. Both pipeline stages are empty.
- Address stage (A) is registered. It holds valid, adr, we, size, prot, lock, wdata and a local-error flag.
  - req_ready_o = ~A.valid | a_done, where a_done = A.valid & HREADY & ~HRESP.
  - On acceptance, A loads on the next edge; the bus sees the address phase one cycle after acceptance.
- Misalignment: a request is misaligned if adr is not a multiple of 2^size, or 2^size > XLEN/8.
  - It sets A.lerr.
  - HTRANS stays IDLE for it; it never goes on the bus.
- HTRANS = NONSEQ when A.valid & ~A.lerr & ~HRESP, otherwise IDLE.
  - HADDR/HWRITE/HSIZE/HPROT/HMASTLOCK mirror A.
  - Outputs hold stable while HREADY=0, except HTRANS is forced IDLE during ERROR cycles.
- Data stage (D) loads from A when a_done. It holds valid, we, wdata and lerr.
  - HWDATA = D.wdata.
  - D clears when HREADY & D.valid and no new a_done occurs.
- Response: when D.valid & HREADY, rsp_valid_o=1 in that same cycle (combinational).
  - rsp_dat_o = HRDATA.
  - rsp_err_o = HRESP | D.lerr.
  - A D entry with lerr completes in the first cycle it is in D, ignoring HREADY.
- ERROR handling:
  - Cycle 1 (HRESP=1, HREADY=0): HTRANS forced IDLE; the pending A entry is held, not cancelled.
  - Cycle 2 (HRESP=1, HREADY=1): error response delivered; A is still not advanced.
  - A is reissued as NONSEQ on the following cycle.
- Ordering: responses are strictly in acceptance order. At most 2 transfers are outstanding (A+D).
- Back-to-back: with zero-wait slaves, a NONSEQ is issued every cycle, giving 1 transfer/cycle throughput.
- Reset mid-transfer: all state clears asynchronously and no response is emitted for in-flight transfers.

Decomposition:
- HTRANS_*, HSIZE_*, HBURST_*, HRESP_* encodings come from the shared AHB3 package already used by the SRAM slave; no local copies.
- Add a packed struct for the stage contents (adr, we, size, prot, lock, wdata, lerr) to that package.
- No sub-module; A and D stages are inline registers.

Test Plan:
- Accept write 0x100 size=WORD data 0xDEADBEEF, then read 0x100 against the SRAM slave -> HTRANS NONSEQ on consecutive cycles; read response rsp_dat_o=0xDEADBEEF, rsp_err_o=0.
- Four back-to-back word writes 0x0..0xC, req_i held high -> req_ready_o high every cycle; 4 NONSEQ in 4 consecutive cycles; 4 rsp_valid_o pulses.
- Slave inserts 2 wait states on a read -> HADDR/HTRANS stable for 3 cycles; req_ready_o=0 while A is full; single rsp_valid_o on the third cycle.
- Slave returns ERROR on a write with a read pending in A -> HTRANS=IDLE in both error cycles; rsp_err_o=1 for the write; read reissued next cycle and completes OK.
- Request adr=0x102 size=WORD -> no NONSEQ on the bus; rsp_valid_o with rsp_err_o=1, in order after the preceding transfer's response.
- Assert HRESETn low during a wait-stated read -> HTRANS=IDLE immediately; no rsp_valid_o after reset release.
